// File: rtl/alu_ram_pkg.sv
// alu_ram_pkg: shared definitions for the alu_ram command sequencer.
//   - default datapath widths (operand, RAM address, result word)
//   - sequencer FSM state encoding (3-bit)
//   - alu_ram opcode values
//   - helper returning the packed width of one queued command
package alu_ram_pkg;

  localparam int DEF_OP_W   = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_RES_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_CAPT  = 3'd4,
    ST_RESP  = 3'd5
  } seq_state_t;

  // Opcodes understood by alu_ram. The sequencer forwards them unchecked.
  typedef enum logic [3:0] {
    OPC_ADD = 4'b0000,
    OPC_SUB = 4'b0001,
    OPC_AND = 4'b0010,
    OPC_OR  = 4'b0011,
    OPC_XOR = 4'b0100,
    OPC_MUL = 4'b0101
  } alu_opc_t;

  // Queued command = {op1, op2, opcode, addr, rdback}.
  function automatic int cmd_entry_w(input int op_w, input int addr_w);
    return 2 * op_w + 4 + addr_w + 1;
  endfunction

endpackage

// File: rtl/alu_ram_seq_cmd_fifo.sv
// seq_cmd_fifo: show-ahead synchronous FIFO for queued sequencer commands.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the queue)
//   push, din     write din when push and not full
//   pop           advance head when pop and not empty
//   dout          current head entry (valid whenever !empty)
//   full, empty   occupancy flags
module seq_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/alu_ram_seq.sv
// alu_ram_seq: command sequencer in front of one alu_ram instance.
// Queues ALU commands, drives operands/opcode/address with a settling cycle,
// pulses the write strobe once per command and optionally reads the word
// back and returns it on a valid/ready response channel.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op1/op2/opcode/addr/rdback  command fields
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_addr              read-back word and its address
//   busy                            queue non-empty or command in flight
//   ops_done                        completed RAM writes (wraps)
//   enb/wr/rd, oparand1/2, opcode,
//   address, address1               alu_ram control and data buses
//   ram_rdata                       alu_ram data_out1
module alu_ram_seq
  import alu_ram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OP_W       = DEF_OP_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RES_W      = DEF_RES_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op1,
  input  logic [OP_W-1:0]   cmd_op2,
  input  logic [3:0]        cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_rdback,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              busy,
  output logic [7:0]        ops_done,
  output logic              enb,
  output logic              wr,
  output logic              rd,
  output logic [OP_W-1:0]   oparand1,
  output logic [OP_W-1:0]   oparand2,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] address,
  output logic [ADDR_W-1:0] address1,
  input  logic [RES_W-1:0]  ram_rdata
);

  localparam int CMD_W = cmd_entry_w(OP_W, ADDR_W);

  logic [CMD_W-1:0]  push_word;
  logic [CMD_W-1:0]  head_word;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;

  logic [OP_W-1:0]   head_op1;
  logic [OP_W-1:0]   head_op2;
  logic [3:0]        head_opcode;
  logic [ADDR_W-1:0] head_addr;
  logic              head_rdback;

  seq_state_t        state_reg;
  logic              rdy_en_reg;
  logic [OP_W-1:0]   op1_reg;
  logic [OP_W-1:0]   op2_reg;
  logic [3:0]        opcode_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr1_reg;
  logic              rdback_reg;
  logic [RES_W-1:0]  rsp_data_reg;
  logic [ADDR_W-1:0] rsp_addr_reg;
  logic [7:0]        ops_done_reg;

  assign push_word   = {cmd_op1, cmd_op2, cmd_opcode, cmd_addr, cmd_rdback};
  assign head_op1    = head_word[CMD_W-1 -: OP_W];
  assign head_op2    = head_word[CMD_W-1-OP_W -: OP_W];
  assign head_opcode = head_word[ADDR_W+1 +: 4];
  assign head_addr   = head_word[1 +: ADDR_W];
  assign head_rdback = head_word[0];

  // rdy_en_reg keeps cmd_ready low while in reset and releases it on the
  // first edge afterwards; the empty FIFO alone would report ready.
  assign cmd_ready = rdy_en_reg && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;

  seq_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_word),
    .pop   (fifo_pop),
    .dout  (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head is latched onto the buses on the pop edge, so the whole LOAD
  // cycle is ALU settling time with the strobes low. Buses are only
  // reloaded on a pop and otherwise hold their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rdy_en_reg   <= 1'b0;
      op1_reg      <= '0;
      op2_reg      <= '0;
      opcode_reg   <= OPC_ADD;
      addr_reg     <= '0;
      addr1_reg    <= '0;
      rdback_reg   <= 1'b0;
      rsp_data_reg <= '0;
      rsp_addr_reg <= '0;
      ops_done_reg <= '0;
    end else begin
      rdy_en_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            op1_reg    <= head_op1;
            op2_reg    <= head_op2;
            opcode_reg <= head_opcode;
            addr_reg   <= head_addr;
            addr1_reg  <= head_addr;
            rdback_reg <= head_rdback;
            state_reg  <= ST_LOAD;
          end
        end
        ST_LOAD:  state_reg <= ST_WRITE;
        ST_WRITE: begin
          ops_done_reg <= ops_done_reg + 8'd1;
          state_reg    <= rdback_reg ? ST_READ : ST_IDLE;
        end
        ST_READ:  state_reg <= ST_CAPT;
        ST_CAPT: begin
          // data_out1 was registered by alu_ram on the READ edge.
          rsp_data_reg <= ram_rdata;
          rsp_addr_reg <= addr1_reg;
          state_reg    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Moore strobes: WRITE and READ are distinct states, so wr and rd can
  // never be high together.
  assign wr        = (state_reg == ST_WRITE);
  assign rd        = (state_reg == ST_READ);
  assign enb       = wr || rd;
  assign rsp_valid = (state_reg == ST_RESP);
  assign busy      = !fifo_empty || (state_reg != ST_IDLE);

  assign oparand1  = op1_reg;
  assign oparand2  = op2_reg;
  assign opcode    = opcode_reg;
  assign address   = addr_reg;
  assign address1  = addr1_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_addr  = rsp_addr_reg;
  assign ops_done  = ops_done_reg;

endmodule

// File: tb/tb_alu_ram_seq.sv
// tb_alu_ram_seq: directed, table-driven bench for alu_ram_seq with a
// behavioural alu_ram model attached to the strobe/bus outputs.
module tb_alu_ram_seq;
  import alu_ram_pkg::*;

  localparam int OP_W   = 8;
  localparam int ADDR_W = 4;
  localparam int RES_W  = 16;
  localparam int WAIT_LIMIT = 3000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op1 = '0;
  logic [OP_W-1:0]   cmd_op2 = '0;
  logic [3:0]        cmd_opcode = '0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic              cmd_rdback = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [RES_W-1:0]  rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              busy;
  logic [7:0]        ops_done;
  logic              enb, wr, rd;
  logic [OP_W-1:0]   oparand1, oparand2;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] address, address1;
  logic [RES_W-1:0]  ram_rdata = '0;

  int tests = 0;
  int fails = 0;
  int overlap_cnt = 0;
  logic [7:0] exp_ops = 8'd0;

  logic [RES_W-1:0]  model_mem [16];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [RES_W-1:0]  wr_data_q[$];

  typedef struct {
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [3:0]  opc;
    logic [3:0]  addr;
    logic        rb;
    logic [15:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  alu_ram_seq #(
    .FIFO_DEPTH(4), .OP_W(OP_W), .ADDR_W(ADDR_W), .RES_W(RES_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_opcode(cmd_opcode),
    .cmd_addr(cmd_addr), .cmd_rdback(cmd_rdback),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .busy(busy), .ops_done(ops_done),
    .enb(enb), .wr(wr), .rd(rd),
    .oparand1(oparand1), .oparand2(oparand2), .opcode(opcode),
    .address(address), .address1(address1),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] opc);
    case (opc)
      4'b0000: return {8'h00, a} + {8'h00, b};
      4'b0001: return {8'h00, a} - {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  // alu_ram model: write on enb&wr, registered read on enb&rd.
  always @(posedge clk) begin
    if (enb && wr) begin
      model_mem[address] <= alu_model(oparand1, oparand2, opcode);
      wr_addr_q.push_back(address);
      wr_data_q.push_back(alu_model(oparand1, oparand2, opcode));
    end
    if (enb && rd) ram_rdata <= model_mem[address1];
    if (wr && rd) overlap_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] opc,
                          input logic [3:0] ad, input logic rb);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op1 = a; cmd_op2 = b; cmd_opcode = opc;
    cmd_addr = ad; cmd_rdback = rb;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++; fails++;
      $display("FAIL push_timeout: got no cmd_ready after %0d cycles, addr %0h", n, ad);
    end else begin
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_LIMIT) check(name, busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n, wr_n, rsp_n, stray;
    logic [15:0] got_data;
    logic [3:0]  got_addr;
    wait_idle("vec_idle");
    wr_addr_q.delete(); wr_data_q.delete();
    push_cmd(v.op1, v.op2, v.opc, v.addr, v.rb);
    n = 0; wr_n = -1; rsp_n = -1; got_data = '0; got_addr = '0;
    while (n < 20 && (wr_n < 0 || (v.rb && rsp_n < 0))) begin
      if (enb && wr && wr_n < 0) wr_n = n;
      if (rsp_valid && rsp_n < 0) begin
        rsp_n = n; got_data = rsp_data; got_addr = rsp_addr;
      end
      @(negedge clk);
      n++;
    end
    exp_ops = exp_ops + 8'd1;
    check($sformatf("vec%0d_wr_latency", idx), wr_n, 2);
    check($sformatf("vec%0d_wr_count", idx), wr_addr_q.size(), 1);
    if (wr_addr_q.size() == 1) begin
      check($sformatf("vec%0d_wr_addr", idx), wr_addr_q[0], v.addr);
      check($sformatf("vec%0d_wr_data", idx), wr_data_q[0], v.exp_data);
    end
    if (v.rb) begin
      check($sformatf("vec%0d_rsp_latency", idx), rsp_n, 5);
      check($sformatf("vec%0d_rsp_data", idx), got_data, v.exp_data);
      check($sformatf("vec%0d_rsp_addr", idx), got_addr, v.addr);
      check($sformatf("vec%0d_rsp_drop", idx), rsp_valid, 0);
    end else begin
      stray = 0;
      for (int k = 0; k < 6; k++) begin
        if (rsp_valid) stray++;
        @(negedge clk);
      end
      check($sformatf("vec%0d_no_rsp", idx), stray, 0);
    end
    wait_idle("vec_idle2");
    check($sformatf("vec%0d_ops_done", idx), ops_done, exp_ops);
  endtask

  initial begin
    int n, hold_err, order_err;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    vecs[0] = '{8'h66, 8'h54, OPC_ADD, 4'h9, 1'b0, 16'h00BA};
    vecs[1] = '{8'h66, 8'h54, OPC_ADD, 4'h3, 1'b1, 16'h00BA};
    vecs[2] = '{8'h12, 8'h34, OPC_ADD, 4'h5, 1'b1, 16'h0046};
    vecs[3] = '{8'hFF, 8'hFF, OPC_ADD, 4'hF, 1'b1, 16'h01FE};
    vecs[4] = '{8'h00, 8'h00, OPC_ADD, 4'h0, 1'b0, 16'h0000};
    vecs[5] = '{8'h80, 8'h01, OPC_ADD, 4'h3, 1'b1, 16'h0081};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_ops_done", ops_done, 0);
    check("rst_strobes", {enb, wr, rd}, 0);
    check("rst_buses", {oparand1, oparand2, address, address1, rsp_data}, 0);
    rst = 1'b0;
    check("rel_cmd_ready_before_edge", cmd_ready, 0);
    @(negedge clk);
    check("rel_cmd_ready_after_edge", cmd_ready, 1);

    // Table vectors
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Backpressure: response held while the queue fills
    wait_idle("bp_idle");
    rsp_ready = 1'b0;
    push_cmd(8'h66, 8'h54, OPC_ADD, 4'h7, 1'b1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_valid", rsp_valid, 1);
    wr_addr_q.delete(); wr_data_q.delete();
    for (int i = 0; i < 4; i++) push_cmd(8'h20 + 8'(i), 8'h03, OPC_ADD, 4'h8 + 4'(i), 1'b0);
    check("bp_full_cmd_ready", cmd_ready, 0);
    check("bp_busy", busy, 1);
    hold_err = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_data !== 16'h00BA || !rsp_valid || cmd_ready) hold_err++;
      @(negedge clk);
    end
    check("bp_hold", hold_err, 0);
    check("bp_rsp_addr", rsp_addr, 4'h7);
    check("bp_no_write", wr_addr_q.size(), 0);
    rsp_ready = 1'b1;
    wait_idle("bp_drain");
    exp_ops = exp_ops + 8'd5;
    check("bp_drain_count", wr_addr_q.size(), 4);
    if (wr_addr_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("bp_order_addr%0d", i), wr_addr_q[i], 4'h8 + 4'(i));
        check($sformatf("bp_order_data%0d", i), wr_data_q[i], 16'h0023 + 16'(i));
      end
    end
    check("bp_ops_done", ops_done, exp_ops);

    // Five back-to-back pushes from IDLE
    wr_addr_q.delete(); wr_data_q.delete();
    for (int i = 1; i <= 5; i++) push_cmd(8'(i), 8'(i), OPC_ADD, 4'(i), 1'b0);
    wait_idle("burst_idle");
    exp_ops = exp_ops + 8'd5;
    check("burst_count", wr_addr_q.size(), 5);
    order_err = 0;
    if (wr_addr_q.size() == 5) begin
      for (int i = 0; i < 5; i++)
        if (wr_addr_q[i] !== 4'(i + 1) || wr_data_q[i] !== 16'(2 * (i + 1))) order_err++;
    end
    check("burst_order", order_err, 0);
    check("burst_ops_done", ops_done, exp_ops);

    // Reset in the middle of a WRITE with another command queued
    wr_addr_q.delete(); wr_data_q.delete();
    push_cmd(8'h11, 8'h22, OPC_ADD, 4'hC, 1'b1);
    push_cmd(8'h33, 8'h44, OPC_ADD, 4'hD, 1'b0);
    n = 0;
    while (!(enb && wr) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_write_seen", enb && wr, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_enb", enb, 0);
    check("mid_rst_wr", wr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ops_done", ops_done, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 8'd0;
    @(negedge clk);
    check("mid_rel_cmd_ready", cmd_ready, 1);
    repeat (8) @(negedge clk);
    check("mid_rel_busy", busy, 0);
    check("mid_no_write", wr_addr_q.size(), 0);
    check("mid_rsp_valid", rsp_valid, 0);

    // 256 write-only commands: ops_done wraps, pointers wrap
    wr_addr_q.delete(); wr_data_q.delete();
    for (int i = 0; i < 256; i++) push_cmd(8'(i), 8'h01, OPC_ADD, 4'(i), 1'b0);
    wait_idle("wrap_idle");
    check("wrap_count", wr_addr_q.size(), 256);
    order_err = 0;
    if (wr_addr_q.size() == 256) begin
      for (int i = 0; i < 256; i++)
        if (wr_addr_q[i] !== 4'(i) || wr_data_q[i] !== 16'(i + 1)) order_err++;
      check("wrap_last_addr", wr_addr_q[255], 4'hF);
      check("wrap_last_data", wr_data_q[255], 16'h0100);
    end
    check("wrap_order", order_err, 0);
    check("wrap_ops_done", ops_done, 0);
    check("strobe_overlap", overlap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
